// File: rtl/expr_pkg.sv
// Shared types and constants for the expr sequencing/accumulation stage.
package expr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        ACCUM,
        DONE
    } state_t;

    localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
    localparam int unsigned EXPR_LAT_DEF = 56;
    localparam int unsigned ADD_LAT_DEF  = 7;
    localparam int unsigned COUNT_W      = 16;

endpackage

// File: rtl/expr_accum_if.sv
// Sample input stream (valid/ready) feeding expr_accum.
interface expr_accum_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        in_last;

    modport master (output in_valid, output in_x, output in_last, input in_ready);
    modport slave  (input in_valid, input in_x, input in_last, output in_ready);

endinterface

// File: rtl/expr_accum_fp_add.sv
// Single-precision adder with a fixed latency (fp_add IP): round-to-nearest-even,
// denormals flushed to zero, overflow saturates to infinity.
module fp_add
    import expr_pkg::*;
#(
    parameter int unsigned LAT = ADD_LAT_DEF
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);

    logic [31:0] res;
    logic [31:0] pipe [LAT-1];

    always_comb begin
        logic [31:0] big, sml;
        logic [7:0]  d;
        logic [26:0] mb, ms;
        logic [27:0] s;
        logic [4:0]  lz;
        logic [9:0]  e;
        logic [24:0] mr;
        logic        rnd;
        big = a;
        sml = b;
        if (b[30:0] > a[30:0]) begin
            big = b;
            sml = a;
        end
        // Mantissas carry three extra bits: guard, round, sticky.
        mb = (big[30:23] == '0) ? '0 : {1'b1, big[22:0], 3'b000};
        ms = (sml[30:23] == '0) ? '0 : {1'b1, sml[22:0], 3'b000};
        d  = big[30:23] - sml[30:23];
        if (d >= 8'd27) ms = {26'b0, |ms};
        else            ms = (ms >> d) | {26'b0, |(ms & ((27'd1 << d) - 27'd1))};
        s  = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
        e  = {2'b00, big[30:23]};
        lz = '0;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            for (int unsigned i = 0; i < 27; i++)
                if (s[i]) lz = 5'(26 - i);
            s = s << lz;
            e = e - {5'b0, lz};
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        mr  = {1'b0, s[26:3]} + {24'b0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        if (s == '0)                 res = FP_ZERO;
        else if (e[9] || e == '0)    res = {big[31], 31'b0};
        else if (e >= 10'd255)       res = {big[31], 8'hFF, 23'b0};
        else                         res = {big[31], e[7:0], mr[22:0]};
    end

    // The consumer samples q on the LAT-th edge after the operands settle,
    // so LAT-1 register stages give exactly LAT cycles of latency.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < LAT-1; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= res;
            for (int unsigned i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LAT-2];

endmodule

// File: rtl/expr_accum.sv
// Serialises x samples through the non-pipelined expr block and accumulates
// f(x) per frame, reporting the frame total and sample count.
module expr_accum
    import expr_pkg::*;
#(
    parameter int unsigned EXPR_LAT = EXPR_LAT_DEF,
    parameter int unsigned ADD_LAT  = ADD_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    expr_accum_if.slave        in_if,
    output logic [31:0]        x_out,
    input  logic [31:0]        expr_q,
    output logic [31:0]        sum,
    output logic               sum_valid,
    output logic [COUNT_W-1:0] count,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(EXPR_LAT > ADD_LAT ? EXPR_LAT : ADD_LAT);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               last_r;
    logic [31:0]        f_r;
    logic [31:0]        acc;
    logic [31:0]        add_q;
    logic [COUNT_W-1:0] n;
    logic               accept;
    logic               cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign accept   = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EVAL;
            EVAL:    if (cnt_zero) state_nxt = ACCUM;
            ACCUM:   if (cnt_zero) state_nxt = last_r ? DONE : IDLE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_if.in_ready = reset && (state == IDLE);
        busy           = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_out     <= FP_ZERO;
            last_r    <= 1'b0;
            cnt       <= '0;
            f_r       <= FP_ZERO;
            acc       <= FP_ZERO;
            n         <= '0;
            sum       <= FP_ZERO;
            count     <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    x_out  <= in_if.in_x;
                    last_r <= in_if.in_last;
                    cnt    <= CNT_W'(EXPR_LAT - 1);
                end
                EVAL: if (cnt_zero) begin
                    f_r <= expr_q;
                    cnt <= CNT_W'(ADD_LAT - 1);
                end else begin
                    cnt <= cnt - 1'b1;
                end
                ACCUM: if (cnt_zero) begin
                    acc <= add_q;
                    n   <= (n == '1) ? n : n + 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: begin
                    sum       <= acc;
                    count     <= n;
                    sum_valid <= 1'b1;
                    acc       <= FP_ZERO;
                    n         <= '0;
                end
                default: ;
            endcase
        end
    end

    // acc and f_r only change on ACCUM entry/exit, so the adder sees stable operands.
    fp_add #(.LAT(ADD_LAT)) u_add (
        .clk    (clk),
        .areset (~reset),
        .a      (acc),
        .b      (f_r),
        .q      (add_q)
    );

endmodule

// File: tb/tb_expr_accum.sv
// Directed bench for expr_accum with an identity delay-line stand-in for expr.
`timescale 1ns/1ps
module tb_expr_accum;
    import expr_pkg::*;

    localparam int unsigned EL = 56;
    localparam int unsigned AL = 7;
    localparam int SAMPLE_CYC = EL + AL + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] x_out, expr_q, sum;
    logic        sum_valid, busy;
    logic [15:0] count;

    expr_accum_if bus ();

    expr_accum #(.EXPR_LAT(EL), .ADD_LAT(AL)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (bus),
        .x_out     (x_out),
        .expr_q    (expr_q),
        .sum       (sum),
        .sum_valid (sum_valid),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // expr stand-in: f(x) = x, result settles just before the EL-th edge.
    logic [31:0] dl [EL-1];
    always @(posedge clk) begin
        dl[0] <= x_out;
        for (int i = 1; i < EL-1; i++) dl[i] <= dl[i-1];
    end
    assign expr_q = dl[EL-2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          cyc = 0;
    int          acc_n = 0, acc_cyc = 0, prev_acc_cyc = 0;
    logic [31:0] cur_x = '0;
    int          sv_n = 0, sv_cyc = 0, xbad = 0;
    logic [31:0] sv_sum = '0;
    logic [15:0] sv_count = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            acc_n++;
            prev_acc_cyc = acc_cyc;
            acc_cyc = cyc + 1;
            cur_x = bus.in_x;
        end else if (busy && x_out !== cur_x) begin
            xbad++;
        end
        if (sum_valid) begin
            sv_n++;
            sv_sum = sum;
            sv_count = count;
            sv_cyc = cyc;
        end
    end

    typedef struct {
        int          n;
        logic [31:0] x [4];
        logic [31:0] sum;
        logic [15:0] cnt;
    } frame_t;

    frame_t tbl [8];

    task automatic set_frame(input int i, input int n, input logic [31:0] x0, input logic [31:0] x1,
                             input logic [31:0] x2, input logic [31:0] x3,
                             input logic [31:0] s, input logic [15:0] c);
        tbl[i].n = n;
        tbl[i].x[0] = x0; tbl[i].x[1] = x1; tbl[i].x[2] = x2; tbl[i].x[3] = x3;
        tbl[i].sum = s;
        tbl[i].cnt = c;
    endtask

    task automatic send(input logic [31:0] x, input logic last);
        int n0;
        bit ok;
        n0 = acc_n;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_last  = last;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (acc_n != n0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sum(input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (sv_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) check("sum_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input int i);
        int s0;
        s0 = sv_n;
        for (int j = 0; j < tbl[i].n; j++) begin
            send(tbl[i].x[j], j == tbl[i].n - 1);
            if (j > 0) check($sformatf("f%0d_spacing", i), 32'(acc_cyc - prev_acc_cyc), 32'(SAMPLE_CYC));
        end
        wait_sum(s0 + 1);
        check($sformatf("f%0d_sum", i), sv_sum, tbl[i].sum);
        check($sformatf("f%0d_count", i), {16'b0, sv_count}, {16'b0, tbl[i].cnt});
        check($sformatf("f%0d_latency", i), 32'(sv_cyc - acc_cyc), 32'(SAMPLE_CYC));
        check($sformatf("f%0d_pulses", i), 32'(sv_n - s0), 32'd1);
    endtask

    logic [31:0] stream_v [4];

    initial begin
        int rel, a0, s0, xb0;

        set_frame(0, 3, 32'h3F800000, 32'h40000000, 32'h40400000, '0, 32'h40C00000, 16'd3);
        set_frame(1, 1, 32'h00000000, '0, '0, '0, 32'h00000000, 16'd1);
        set_frame(2, 1, 32'h3F800000, '0, '0, '0, 32'h3F800000, 16'd1);
        set_frame(3, 2, 32'h40000000, 32'h40000000, '0, '0, 32'h40800000, 16'd2);
        set_frame(4, 2, 32'h3FC00000, 32'h3F000000, '0, '0, 32'h40000000, 16'd2);
        set_frame(5, 2, 32'h3F800000, 32'hBF800000, '0, '0, 32'h00000000, 16'd2);
        set_frame(6, 2, 32'h41200000, 32'h3E800000, '0, '0, 32'h41240000, 16'd2);
        set_frame(7, 4, 32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000, 32'h41400000, 16'd4);
        stream_v[0] = 32'h3F800000; stream_v[1] = 32'h40000000;
        stream_v[2] = 32'h40400000; stream_v[3] = 32'h40800000;

        // Reset held with a pending sample: nothing accepted, outputs at reset values.
        bus.in_valid = 1'b1;
        bus.in_x     = 32'h3F800000;
        bus.in_last  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_count", {16'b0, count}, 32'd0);
        check("rst_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("rst_x_out", x_out, 32'd0);
        check("rst_no_accept", 32'(acc_n), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rel = cyc;
        for (int k = 0; k < 10 && acc_n == 0; k++) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rel_accept_cycle", 32'(acc_cyc), 32'(rel + 1));
        wait_sum(1);
        check("rel_sum", sv_sum, 32'h3F800000);
        check("rel_count", {16'b0, sv_count}, 32'd1);

        for (int i = 0; i < 8; i++) run_frame(i);
        check("sum_hold", sum, 32'h41400000);
        check("count_hold", {16'b0, count}, 32'd4);

        // in_valid held while in_x changes every cycle: one accept per IDLE visit.
        a0 = acc_n;
        s0 = sv_n;
        xb0 = xbad;
        for (int k = 0; k < 140; k++) begin
            bus.in_valid = 1'b1;
            bus.in_last  = 1'b1;
            bus.in_x     = stream_v[cyc % 4];
            @(posedge clk);
            #1;
            if (acc_n != a0 && acc_n - a0 >= 2 && acc_cyc == cyc)
                check("stream_spacing", 32'(acc_cyc - prev_acc_cyc), 32'(SAMPLE_CYC + 1));
        end
        bus.in_valid = 1'b0;
        check("stream_accepts", 32'(acc_n - a0), 32'd3);
        wait_sum(s0 + (acc_n - a0));
        check("stream_sums", 32'(sv_n - s0), 32'(acc_n - a0));
        check("stream_last_sum", sv_sum, cur_x);
        check("stream_count", {16'b0, sv_count}, 32'd1);
        check("x_out_stable", 32'(xbad - xb0), 32'd0);

        // Reset in EVAL of the second sample aborts the frame silently.
        s0 = sv_n;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", {31'b0, busy}, 32'd0);
        check("mid_sum", sum, 32'd0);
        check("mid_count", {16'b0, count}, 32'd0);
        check("mid_x_out", x_out, 32'd0);
        check("mid_in_ready", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("mid_no_sum_valid", 32'(sv_n - s0), 32'd0);
        run_frame(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
